// File: rtl/dec_pfx_seq_pkg.sv
// Shared definitions for the BJX1 fetch-to-decode prefix sequencer:
// prefix opcodes, state encoding and the decode bundle layout.
package dec_pfx_seq_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned BUNDLE_W = 32;
    localparam int unsigned CNT_W    = 16;

    localparam logic [7:0] PFX_XE8 = 8'h8E;
    localparam logic [7:0] PFX_XEC = 8'hCE;

    typedef enum logic {
        PFXSEQ_EMPTY = 1'b0,
        PFXSEQ_HOLD  = 1'b1
    } pfxseq_state_e;

    // istrWord layout: opcode word high, prefix word low
    typedef struct packed {
        logic [WORD_W-1:0] opcode;
        logic [WORD_W-1:0] prefix;
    } istr_word_t;

    function automatic logic is_prefix(input logic [WORD_W-1:0] w);
        return (w[15:8] == PFX_XE8) || (w[15:8] == PFX_XEC);
    endfunction

endpackage

// File: rtl/dec_pfx_seq.sv
// Joins an 8Exx/CExx prefix word with the following opcode word into one
// registered 32-bit decode bundle; plain words pass through as {word, 0}.
module dec_pfx_seq
    import dec_pfx_seq_pkg::*;
#(
    parameter int unsigned PC_BITS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WORD_W-1:0]   ifWord,
    input  logic [PC_BITS-1:0]  ifPc,
    input  logic                ifValid,
    output logic                ifReady,
    input  logic                iFlush,
    output logic [BUNDLE_W-1:0] idWord,
    output logic [PC_BITS-1:0]  idPc,
    output logic                idIsXE,
    output logic                idBadPfx,
    output logic                idValid,
    input  logic                idReady,
    output logic [CNT_W-1:0]    oPairCnt
);

    pfxseq_state_e      r_state;
    logic [WORD_W-1:0]  r_hold_word;
    logic [PC_BITS-1:0] r_hold_pc;
    istr_word_t         r_word;
    logic [PC_BITS-1:0] r_pc;
    logic               r_xe;
    logic               r_bad;
    logic               r_valid;
    logic [CNT_W-1:0]   r_pair_cnt;

    pfxseq_state_e      w_state_nxt;
    logic [WORD_W-1:0]  w_hold_word_nxt;
    logic [PC_BITS-1:0] w_hold_pc_nxt;
    istr_word_t         w_word_nxt;
    logic [PC_BITS-1:0] w_pc_nxt;
    logic               w_xe_nxt;
    logic               w_bad_nxt;
    logic               w_valid_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_load;
    logic               w_xfer;
    logic               w_is_pfx;

    // Only combinational output: accept when the output slot is free or draining
    assign ifReady  = !reset && !iFlush && (!r_valid || idReady);
    assign w_xfer   = ifValid && ifReady;
    assign w_is_pfx = is_prefix(ifWord);

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_word_nxt = r_hold_word;
        w_hold_pc_nxt   = r_hold_pc;
        w_word_nxt      = r_word;
        w_pc_nxt        = r_pc;
        w_xe_nxt        = r_xe;
        w_bad_nxt       = r_bad;
        w_valid_nxt     = r_valid;
        w_cnt_nxt       = r_pair_cnt;
        w_load          = 1'b0;

        if (iFlush) begin
            // Flush beats a simultaneous consume: the bundle is dropped
            w_state_nxt     = PFXSEQ_EMPTY;
            w_hold_word_nxt = '0;
            w_hold_pc_nxt   = '0;
            w_valid_nxt     = 1'b0;
        end else begin
            if (w_xfer) begin
                case (r_state)
                    PFXSEQ_EMPTY: begin
                        if (w_is_pfx) begin
                            w_hold_word_nxt = ifWord;
                            w_hold_pc_nxt   = ifPc;
                            w_state_nxt     = PFXSEQ_HOLD;
                        end else begin
                            w_load     = 1'b1;
                            w_word_nxt = '{opcode: ifWord, prefix: '0};
                            w_pc_nxt   = ifPc;
                            w_xe_nxt   = 1'b0;
                            w_bad_nxt  = 1'b0;
                        end
                    end
                    PFXSEQ_HOLD: begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_hold_pc;
                        w_xe_nxt = 1'b1;
                        if (w_is_pfx) begin
                            // Prefix after prefix: emit the old one as bad, keep the new one
                            w_word_nxt      = '{opcode: '0, prefix: r_hold_word};
                            w_bad_nxt       = 1'b1;
                            w_hold_word_nxt = ifWord;
                            w_hold_pc_nxt   = ifPc;
                        end else begin
                            w_word_nxt      = '{opcode: ifWord, prefix: r_hold_word};
                            w_bad_nxt       = 1'b0;
                            w_cnt_nxt       = r_pair_cnt + CNT_W'(1);
                            w_hold_word_nxt = '0;
                            w_hold_pc_nxt   = '0;
                            w_state_nxt     = PFXSEQ_EMPTY;
                        end
                    end
                    default: w_state_nxt = PFXSEQ_EMPTY;
                endcase
            end

            if (w_load) begin
                w_valid_nxt = 1'b1;
            end else if (idReady && r_valid) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= PFXSEQ_EMPTY;
            r_hold_word <= '0;
            r_hold_pc   <= '0;
            r_word      <= '0;
            r_pc        <= '0;
            r_xe        <= 1'b0;
            r_bad       <= 1'b0;
            r_valid     <= 1'b0;
            r_pair_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_word <= w_hold_word_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
            r_word      <= w_word_nxt;
            r_pc        <= w_pc_nxt;
            r_xe        <= w_xe_nxt;
            r_bad       <= w_bad_nxt;
            r_valid     <= w_valid_nxt;
            r_pair_cnt  <= w_cnt_nxt;
        end
    end

    assign idWord   = r_word;
    assign idPc     = r_pc;
    assign idIsXE   = r_xe;
    assign idBadPfx = r_bad;
    assign idValid  = r_valid;
    assign oPairCnt = r_pair_cnt;

endmodule
